icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 152 +++++++++++++++
 tb/tb_icache.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 16 lines x 4 words, zero-latency hit.
// A miss stalls fetch while the line is refilled one word per accepted mem_ack.
// Optional feature macro: ICACHE_PERF_EN (adds hit_count/miss_count outputs).
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   pc, fetch_en, flush  fetch address, fetch request, invalidate all lines
//   instr, stall         instruction word for pc, fetch not satisfied
//   mem_req, mem_addr    refill word request and word-aligned address
//   mem_ack, mem_rdata   refill word handshake and data
//   hit_count, miss_count (ICACHE_PERF_EN only) saturating performance counters
module icache (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LINES  = 16;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TAG_W  = 24;
    localparam int unsigned LINE_W = TAG_W + IDX_W;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } state_e;

    state_e             state_q;
    logic [OFF_W-1:0]   cnt_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINES-1:0]   valid_q;
    logic               flushed_q;
    logic [DATA_W-1:0]  data_q [LINES][WORDS];
    logic [TAG_W-1:0]   tag_q  [LINES];

    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   line_idx;
    logic [TAG_W-1:0]   line_tag;
    logic               hit;
    logic               last_ack;
    logic               unused_pc;

    assign pc_off    = pc[3:2];
    assign pc_idx    = pc[7:4];
    assign pc_tag    = pc[31:8];
    assign line_idx  = line_q[IDX_W-1:0];
    assign line_tag  = line_q[LINE_W-1:IDX_W];
    assign unused_pc = ^pc[1:0];

    // Zero-latency lookup; only meaningful while idle in LOOKUP.
    assign hit      = (state_q == LOOKUP) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign instr    = data_q[pc_idx][pc_off];
    assign stall    = (state_q != LOOKUP) || (fetch_en && !hit);
    assign last_ack = (state_q == REFILL) && mem_ack && (cnt_q == OFF_W'(WORDS - 1));

    // Refill request decoded from registered state, so reset drops it at once.
    assign mem_req  = (state_q == REFILL);
    assign mem_addr = mem_req ? {line_q, cnt_q, 2'b00} : 32'h0;

    // Control state: FSM, word counter, latched line address, valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LOOKUP;
            cnt_q     <= '0;
            line_q    <= '0;
            valid_q   <= '0;
            flushed_q <= 1'b0;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (flush) begin
                        valid_q <= '0;
                    end
                    if (fetch_en && !hit) begin
                        state_q   <= REFILL;
                        line_q    <= pc[31:4];
                        cnt_q     <= '0;
                        flushed_q <= 1'b0;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        valid_q   <= '0;
                        flushed_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        cnt_q <= OFF_W'(cnt_q + OFF_W'(1));
                    end
                    if (last_ack) begin
                        state_q <= LOOKUP;
                        // A flush seen at any point of the refill leaves the line invalid.
                        if (!flushed_q && !flush) begin
                            valid_q[line_idx] <= 1'b1;
                        end
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if ((state_q == REFILL) && mem_ack) begin
            data_q[line_idx][cnt_q] <= mem_rdata;
        end
        if (last_ack) begin
            tag_q[line_idx] <= line_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Saturating hit/miss counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (fetch_en && hit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == LOOKUP) && fetch_en && !hit && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache.
// Backing memory returns mem_word(addr) for every refill address.
module tb_icache;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks;
    int failures;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; pc = 32'hBFC0_0000; fetch_en = 1'b1; flush = 1'b0; mem_ack = 1'b0;
        #12;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", stall); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        fetch_en = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
`ifdef ICACHE_PERF_EN
        checks++; if (hit_count !== 32'h0) begin failures++; $display("FAIL reset_hit_count got=%h exp=0", hit_count); end
        checks++; if (miss_count !== 32'h0) begin failures++; $display("FAIL reset_miss_count got=%h exp=0", miss_count); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_cold_miss;
        pc = 32'hBFC0_0000; fetch_en = 1'b1; mem_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cold_stall_c0 got=%b exp=1", stall); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_req_c0 got=%b exp=0", mem_req); end
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            #1;
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL cold_req_w%0d got=%b exp=1", i, mem_req); end
            checks++; if (mem_addr !== 32'hBFC0_0000 + 32'(4 * i)) begin failures++; $display("FAIL cold_addr_w%0d got=%h exp=%h", i, mem_addr, 32'hBFC0_0000 + 32'(4 * i)); end
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cold_stall_w%0d got=%b exp=1", i, stall); end
        end
        ticks(1);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL cold_hit_stall got=%b exp=0", stall); end
        checks++; if (instr !== mem_word(32'hBFC0_0000)) begin failures++; $display("FAIL cold_hit_instr got=%h exp=%h", instr, mem_word(32'hBFC0_0000)); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_hit_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_hit;
        pc = 32'hBFC0_0008;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hit_stall got=%b exp=0", stall); end
        checks++; if (instr !== mem_word(32'hBFC0_0008)) begin failures++; $display("FAIL hit_instr got=%h exp=%h", instr, mem_word(32'hBFC0_0008)); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_req got=%b exp=0", mem_req); end
        pc = 32'hBFC0_000C;
        #1;
        checks++; if (instr !== mem_word(32'hBFC0_000C)) begin failures++; $display("FAIL hit_instr_w3 got=%h exp=%h", instr, mem_word(32'hBFC0_000C)); end
    endtask

    task automatic test_conflict;
        ticks(1);
        pc = 32'hBFC0_0100;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL conf_miss got=%b exp=1", stall); end
        ticks(1);
        #1;
        checks++; if (mem_addr !== 32'hBFC0_0100) begin failures++; $display("FAIL conf_addr got=%h exp=BFC00100", mem_addr); end
        ticks(4);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL conf_hit_stall got=%b exp=0", stall); end
        checks++; if (instr !== mem_word(32'hBFC0_0100)) begin failures++; $display("FAIL conf_hit_instr got=%h exp=%h", instr, mem_word(32'hBFC0_0100)); end
        pc = 32'hBFC0_0000;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL conf_evicted got=%b exp=1", stall); end
        ticks(5);
        #1;
        checks++; if (instr !== mem_word(32'hBFC0_0000) || stall !== 1'b0) begin failures++; $display("FAIL conf_restore got=%h/%b exp=%h/0", instr, stall, mem_word(32'hBFC0_0000)); end
    endtask

    task automatic test_flush;
        ticks(1);
        pc = 32'hBFC0_0020;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_miss got=%b exp=1", stall); end
        ticks(3);
        flush = 1'b1;
        #1;
        checks++; if (mem_addr !== 32'hBFC0_0028) begin failures++; $display("FAIL flush_addr_w2 got=%h exp=BFC00028", mem_addr); end
        ticks(1);
        flush = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_002C) begin failures++; $display("FAIL flush_addr_w3 got=%b/%h exp=1/BFC0002C", mem_req, mem_addr); end
        ticks(1);
        #1;
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL flush_line_invalid got=%b/%b exp=1/0", stall, mem_req); end
        ticks(1);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0020) begin failures++; $display("FAIL flush_rerefill got=%b/%h exp=1/BFC00020", mem_req, mem_addr); end
        ticks(4);
        #1;
        checks++; if (stall !== 1'b0 || instr !== mem_word(32'hBFC0_0020)) begin failures++; $display("FAIL flush_rehit got=%b/%h exp=0/%h", stall, instr, mem_word(32'hBFC0_0020)); end
        pc = 32'hBFC0_0000;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_other_line got=%b exp=1", stall); end
        pc = 32'hBFC0_0024; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || instr !== mem_word(32'hBFC0_0024)) begin failures++; $display("FAIL flush_same_cycle got=%b/%h exp=0/%h", stall, instr, mem_word(32'hBFC0_0024)); end
        ticks(1);
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_lookup_clear got=%b exp=1", stall); end
        fetch_en = 1'b0;
    endtask

    task automatic test_async_reset;
        ticks(1);
        pc = 32'hBFC0_0030; fetch_en = 1'b1; mem_ack = 1'b0;
        ticks(1);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0030) begin failures++; $display("FAIL ar_addr_w0 got=%b/%h exp=1/BFC00030", mem_req, mem_addr); end
        ticks(1);
        #1;
        checks++; if (mem_addr !== 32'hBFC0_0030 || stall !== 1'b1) begin failures++; $display("FAIL ar_ack_wait got=%h/%b exp=BFC00030/1", mem_addr, stall); end
        mem_ack = 1'b1;
        ticks(1);
        mem_ack = 1'b0;
        #1;
        checks++; if (mem_addr !== 32'hBFC0_0034) begin failures++; $display("FAIL ar_addr_w1 got=%h exp=BFC00034", mem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL ar_req_drop got=%b/%h exp=0/0", mem_req, mem_addr); end
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL ar_post_miss got=%b/%b exp=1/0", stall, mem_req); end
        ticks(1);
        #1;
        checks++; if (mem_addr !== 32'hBFC0_0030) begin failures++; $display("FAIL ar_restart_w0 got=%h exp=BFC00030", mem_addr); end
        ticks(4);
        #1;
        checks++; if (stall !== 1'b0 || instr !== mem_word(32'hBFC0_0030)) begin failures++; $display("FAIL ar_rehit got=%b/%h exp=0/%h", stall, instr, mem_word(32'hBFC0_0030)); end
    endtask

`ifdef ICACHE_PERF_EN
    task automatic test_perf;
        @(negedge clk);
        rst = 1'b0; fetch_en = 1'b0;
        #1;
        checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin failures++; $display("FAIL perf_reset got=%h/%h exp=0/0", hit_count, miss_count); end
        @(negedge clk);
        rst = 1'b1; pc = 32'hBFC0_0040; fetch_en = 1'b1; mem_ack = 1'b1;
        ticks(8);
        fetch_en = 1'b0;
        #1;
        checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL perf_miss got=%0d exp=1", miss_count); end
        checks++; if (hit_count !== 32'd3) begin failures++; $display("FAIL perf_hit got=%0d exp=3", hit_count); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_async_reset();
`ifdef ICACHE_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
